// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides,
// a persistent flags register, carry-chained ADC/SBB, shifts, compare and an
// illegal-opcode indication. ALU_OUT is tri-stated by OE.
// Optional feature: define ALU_PIPE_MUL_EN to enable opcode 1110 as MUL.
module alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       OPCODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             OE,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             CF,
  output logic             OF,
  output logic             SF,
  output logic             ZF,
  output logic             ERR
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_ADC = 4'b1000;
  localparam logic [3:0] OP_SBB = 4'b1001;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_SHR = 4'b1011;
  localparam logic [3:0] OP_SAR = 4'b1100;
  localparam logic [3:0] OP_CMP = 4'b1101;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1110;
`endif

  // Stage 1 operation register
  logic             s1_valid_q;
  logic [3:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // Stage 2 result/flags register
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic             sf_q, sf_d;
  logic             zf_q, zf_d;
  logic             err_q, err_d;

  logic             load_c;
  logic             accept_c;

  // Datapath intermediates
  logic             cin_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [SHW-1:0]   sh_n_c;
  logic             sh_over_c;
  logic [WIDTH:0]   shl_c;
  logic [WIDTH:0]   shr_c;
  logic signed [WIDTH:0] sar_c;
  logic [WIDTH-1:0] sz_src_c;
  logic             sz_en_c;
`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] prod_c;
`endif

  assign load_c   = s1_valid_q && (!out_valid_q || OUT_READY);
  assign IN_READY = !s1_valid_q || load_c;
  assign accept_c = IN_VALID && IN_READY;

  // Shared adder/subtractor and shifters; an extra bit catches carry/borrow or the shifted-out bit
  always_comb begin
    cin_c     = (s1_op_q == OP_ADC || s1_op_q == OP_SBB) ? cf_q : 1'b0;
    sum_c     = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, cin_c};
    diff_c    = {1'b0, s1_a_q} - {1'b0, s1_b_q} - {{WIDTH{1'b0}}, cin_c};
    sh_n_c    = s1_b_q[SHW-1:0];
    sh_over_c = sh_n_c > SHW'(WIDTH);
    shl_c     = {1'b0, s1_a_q} << sh_n_c;
    shr_c     = {s1_a_q, 1'b0} >> sh_n_c;
    sar_c     = $signed({s1_a_q, 1'b0}) >>> sh_n_c;
  end

`ifdef ALU_PIPE_MUL_EN
  // Single-cycle unsigned multiply
  assign prod_c = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
`endif

  // Next result/flags; anything not touched by the opcode holds its value
  always_comb begin
    res_d    = res_q;
    cf_d     = cf_q;
    of_d     = of_q;
    sf_d     = sf_q;
    zf_d     = zf_q;
    err_d    = 1'b0;
    sz_src_c = '0;
    sz_en_c  = 1'b0;
    case (s1_op_q)
      OP_NOP: ;
      OP_ADD, OP_ADC: begin
        res_d    = sum_c[MSB:0];
        cf_d     = sum_c[WIDTH];
        of_d     = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum_c[MSB] != s1_a_q[MSB]);
        sz_src_c = sum_c[MSB:0];
        sz_en_c  = 1'b1;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        if (s1_op_q != OP_CMP) res_d = diff_c[MSB:0];
        cf_d     = diff_c[WIDTH];
        of_d     = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff_c[MSB] != s1_a_q[MSB]);
        sz_src_c = diff_c[MSB:0];
        sz_en_c  = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        case (s1_op_q)
          OP_AND:  res_d = s1_a_q & s1_b_q;
          OP_OR:   res_d = s1_a_q | s1_b_q;
          OP_XOR:  res_d = s1_a_q ^ s1_b_q;
          default: res_d = ~s1_a_q;
        endcase
        cf_d     = 1'b0;
        of_d     = 1'b0;
        sz_src_c = res_d;
        sz_en_c  = 1'b1;
      end
      OP_SHL: begin
        res_d    = shl_c[MSB:0];
        cf_d     = shl_c[WIDTH];
        of_d     = 1'b0;
        sz_src_c = shl_c[MSB:0];
        sz_en_c  = 1'b1;
      end
      OP_SHR: begin
        res_d    = shr_c[WIDTH:1];
        cf_d     = shr_c[0];
        of_d     = 1'b0;
        sz_src_c = shr_c[WIDTH:1];
        sz_en_c  = 1'b1;
      end
      OP_SAR: begin
        // sign fill saturates past WIDTH, but nothing real was shifted out
        res_d    = sar_c[WIDTH:1];
        cf_d     = sar_c[0] && !sh_over_c;
        of_d     = 1'b0;
        sz_src_c = sar_c[WIDTH:1];
        sz_en_c  = 1'b1;
      end
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: begin
        res_d    = prod_c[MSB:0];
        cf_d     = |prod_c[2*WIDTH-1:WIDTH];
        of_d     = |prod_c[2*WIDTH-1:WIDTH];
        sz_src_c = prod_c[MSB:0];
        sz_en_c  = 1'b1;
      end
`endif
      default: err_d = 1'b1;
    endcase
    if (sz_en_c) begin
      sf_d = sz_src_c[MSB];
      zf_d = (sz_src_c == '0);
    end
  end

  // Stage 1: capture an accepted operation
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (accept_c) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= OPCODE;
      s1_a_q     <= A;
      s1_b_q     <= B;
    end else if (load_c) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: load result and flags, hold the beat until the consumer takes it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
      sf_q        <= 1'b0;
      zf_q        <= 1'b0;
      err_q       <= 1'b0;
    end else if (load_c) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
      cf_q        <= cf_d;
      of_q        <= of_d;
      sf_q        <= sf_d;
      zf_q        <= zf_d;
      err_q       <= err_d;
    end else if (OUT_READY) begin
      out_valid_q <= 1'b0;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign ALU_OUT   = OE ? res_q : {WIDTH{1'bz}};
  assign CF        = cf_q;
  assign OF        = of_q;
  assign SF        = sf_q;
  assign ZF        = zf_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for alu_pipe with a behavioural reference model
// and a per-cycle output comparator, plus hand-computed literal checks.
module tb_alu_pipe;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h2, SUB = 4'h3, AND_ = 4'h4, OR_ = 4'h5,
                         XOR_ = 4'h6, NOT_ = 4'h7, ADC = 4'h8, SBB = 4'h9, SHL = 4'hA,
                         SHR = 4'hB, SAR = 4'hC, CMP = 4'hD;

  typedef struct packed {
    logic [7:0] res;
    logic       cf;
    logic       ovf;
    logic       sf;
    logic       zf;
    logic       err;
  } beat_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [3:0] OPCODE = '0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b1;
  logic       OE = 1'b1;
  wire  [7:0] alu_out;
  logic       CF, OF, SF, ZF, ERR;

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  beat_t mstate = '0;

  vec_t vtab [21] = '{
    '{ADD, 8'h7F, 8'h01}, '{ADD, 8'hFF, 8'h01}, '{ADC, 8'h00, 8'h00}, '{SUB, 8'h00, 8'h01},
    '{SBB, 8'h05, 8'h02}, '{SBB, 8'h80, 8'h00}, '{AND_, 8'hF0, 8'h3C}, '{OR_, 8'hF0, 8'h0C},
    '{XOR_, 8'hFF, 8'h0F}, '{NOT_, 8'h5A, 8'h00}, '{SHL, 8'h81, 8'h00}, '{SHL, 8'h81, 8'h01},
    '{SHR, 8'h81, 8'h08}, '{SAR, 8'h81, 8'h08}, '{SAR, 8'h81, 8'h0A}, '{SHR, 8'h81, 8'h09},
    '{CMP, 8'h20, 8'h30}, '{NOP, 8'h00, 8'h00}, '{4'h1, 8'h12, 8'h34}, '{SUB, 8'h80, 8'h01},
    '{SBB, 8'h7F, 8'h80}
  };

  alu_pipe #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OE(OE), .ALU_OUT(alu_out), .CF(CF), .OF(OF), .SF(SF), .ZF(ZF), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: what one operation does to the architectural result/flags
  function automatic beat_t model(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input beat_t st);
    beat_t r;
    int s, sv, c, n;
    logic [7:0] v;
    logic co;
    r = st;
    r.err = 1'b0;
    c = (op == ADC || op == SBB) ? int'(st.cf) : 0;
    case (op)
      NOP: ;
      ADD, ADC: begin
        s  = int'(a) + int'(b) + c;
        sv = int'($signed(a)) + int'($signed(b)) + c;
        r.res = s[7:0]; r.cf = (s > 255); r.ovf = (sv > 127) || (sv < -128);
        r.sf = r.res[7]; r.zf = (r.res == 8'h00);
      end
      SUB, SBB, CMP: begin
        s  = int'(a) - int'(b) - c;
        sv = int'($signed(a)) - int'($signed(b)) - c;
        v  = s[7:0];
        if (op != CMP) r.res = v;
        r.cf = (s < 0); r.ovf = (sv > 127) || (sv < -128);
        r.sf = v[7]; r.zf = (v == 8'h00);
      end
      AND_, OR_, XOR_, NOT_: begin
        if (op == AND_)      r.res = a & b;
        else if (op == OR_)  r.res = a | b;
        else if (op == XOR_) r.res = a ^ b;
        else                 r.res = ~a;
        r.cf = 1'b0; r.ovf = 1'b0; r.sf = r.res[7]; r.zf = (r.res == 8'h00);
      end
      SHL, SHR, SAR: begin
        n = int'(b[3:0]);
        v = a; co = 1'b0;
        for (int i = 0; i < n; i++) begin
          if (op == SHL) begin co = v[7]; v = v << 1; end
          else if (op == SHR) begin co = v[0]; v = v >> 1; end
          else begin co = v[0]; v = {v[7], v[7:1]}; end
        end
        if (n > 8) co = 1'b0;
        r.res = v; r.cf = co; r.ovf = 1'b0; r.sf = v[7]; r.zf = (v == 8'h00);
      end
`ifdef ALU_PIPE_MUL_EN
      4'hE: begin
        s = int'(a) * int'(b);
        r.res = s[7:0]; r.cf = (s > 255); r.ovf = (s > 255);
        r.sf = r.res[7]; r.zf = (r.res == 8'h00);
      end
`endif
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Comparator: every valid output beat is checked against the model's queue
  always @(negedge CLK) begin
    beat_t e;
    if (!RST_N) begin
      exp_q.delete();
      mstate = '0;
    end else begin
      if (OUT_VALID) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=valid required=idle");
        end else begin
          e = exp_q[0];
          if (OE) chk("beat_result", 32'(alu_out), 32'(e.res));
          chk("beat_flags_cf_of_sf_zf_err", 32'({CF, OF, SF, ZF, ERR}),
              32'({e.cf, e.ovf, e.sf, e.zf, e.err}));
          if (OUT_READY) void'(exp_q.pop_front());
        end
      end
      if (IN_VALID && IN_READY) begin
        mstate = model(OPCODE, A, B, mstate);
        exp_q.push_back(mstate);
      end
    end
  end

  // Present one op and hold it until the DUT accepts it; returns 1ns after the accepting edge
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic acc;
    int waited;
    OPCODE = op; A = a; B = b; IN_VALID = 1'b1;
    acc = 1'b0; waited = 0;
    while (!acc) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      waited++;
      if (!acc && waited > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=not_accepted required=accepted op=%h", op);
        break;
      end
    end
    IN_VALID = 1'b0;
  endtask

  // Single op followed by the edge that loads its result
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    send(op, a, b);
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || OUT_VALID) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // reset state
    #2 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
    chk("reset_alu_out", 32'(alu_out), 32'h00);
    chk("reset_flags", 32'({CF, OF, SF, ZF, ERR}), 32'd0);
    chk("reset_in_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // ADD 7F+01: signed overflow; beat appears on the edge after acceptance
    send(ADD, 8'h7F, 8'h01);
    chk("add_not_yet_valid", 32'(OUT_VALID), 32'd0);
    @(posedge CLK); #1;
    chk("add_valid", 32'(OUT_VALID), 32'd1);
    chk("add_result", 32'(alu_out), 32'h80);
    chk("add_flags_cf_of_sf_zf", 32'({CF, OF, SF, ZF}), 32'b0110);

    // ADD FF+01 then ADC 00+00 back to back: carry chains into ADC
    send(ADD, 8'hFF, 8'h01);
    send(ADC, 8'h00, 8'h00);
    chk("carry_add_result", 32'(alu_out), 32'h00);
    chk("carry_add_cf_zf", 32'({CF, ZF}), 32'b11);
    @(posedge CLK); #1;
    chk("adc_result", 32'(alu_out), 32'h01);
    chk("adc_cf", 32'(CF), 32'd0);

    // SUB with borrow, then CMP leaves the result register alone
    do_op(SUB, 8'h10, 8'h20);
    chk("sub_result", 32'(alu_out), 32'hF0);
    chk("sub_cf_sf", 32'({CF, SF}), 32'b11);
    do_op(CMP, 8'h05, 8'h05);
    chk("cmp_zf", 32'(ZF), 32'd1);
    chk("cmp_result_held", 32'(alu_out), 32'hF0);

    // shift boundaries
    do_op(SAR, 8'h81, 8'd1);
    chk("sar1_result_cf", 32'({alu_out, CF}), 32'({8'hC0, 1'b1}));
    do_op(SHL, 8'h81, 8'd8);
    chk("shl8_result_cf", 32'({alu_out, CF}), 32'({8'h00, 1'b1}));
    do_op(SHR, 8'hFF, 8'd9);
    chk("shr9_result_cf", 32'({alu_out, CF}), 32'({8'h00, 1'b0}));

    // illegal opcode keeps result and flags, raises ERR
    do_op(SUB, 8'h10, 8'h20);
    do_op(4'hF, 8'h33, 8'h44);
    chk("illegal_err", 32'(ERR), 32'd1);
    chk("illegal_result_held", 32'(alu_out), 32'hF0);
    chk("illegal_flags_held", 32'({CF, OF, SF, ZF}), 32'b1010);

    // OE low releases the bus; flags still driven
    OE = 1'b0;
    #1;
    checks++;
    if (alu_out === 8'hF0) begin
      errors++;
      $display("FAIL oe_low_bus actual=%h required=zz", alu_out);
    end
    chk("oe_low_flags", 32'({CF, SF}), 32'b11);
    OE = 1'b1;
    @(posedge CLK); #1;
    do_op(NOP, 8'h00, 8'h00);
    chk("nop_err_clear", 32'(ERR), 32'd0);
    chk("nop_result_held", 32'(alu_out), 32'hF0);
    drain();

    // directed vector stream against the model with a fixed stall pattern
    fork
      begin
        for (int i = 0; i < 21; i++) send(vtab[i].op, vtab[i].a, vtab[i].b);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          OUT_READY = (i % 3) != 1;
          @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
      end
    join
    drain();

    // backpressure: consumer stalls four cycles while inputs stream
    OUT_READY = 1'b0;
    fork
      begin
        send(ADD, 8'h01, 8'h01);
        send(ADD, 8'h02, 8'h02);
        send(ADD, 8'h03, 8'h03);
        send(ADD, 8'h04, 8'h04);
      end
      begin
        repeat (3) @(posedge CLK);
        #1;
        chk("bp_in_ready_low", 32'(IN_READY), 32'd0);
        chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
        chk("bp_beat_held_1", 32'(alu_out), 32'h02);
        @(posedge CLK); #1;
        chk("bp_beat_held_2", 32'(alu_out), 32'h02);
        OUT_READY = 1'b1;
      end
    join
    drain();

    // reset with two operations in flight
    send(ADD, 8'h7F, 8'h01);
    send(SUB, 8'h10, 8'h20);
    RST_N = 1'b0;
    #1;
    chk("rst_flight_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_flight_alu_out", 32'(alu_out), 32'h00);
    chk("rst_flight_flags", 32'({CF, OF, SF, ZF, ERR}), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("rst_no_ghost_beat", 32'(OUT_VALID), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
